// File: rtl/traffic_pkg.sv
// Shared types and helpers for the N-lane traffic-light controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    ALLRED = 2'd2,
    FLASH  = 2'd3
  } phase_e;

  localparam int DEFAULT_TW = 8;

  // A zero preset would make a phase vanish; treat it as a one-tick phase.
  function automatic logic [31:0] eff_preset(input logic [31:0] p);
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times the current phase; holds at 1 (or 0) until reloaded.
module phase_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          en,
  output logic [TW-1:0] count,
  output logic          last
);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // Load wins over counting; never count below 1 so a stalled phase stays "last".
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q > TW'(1))) begin
      count_d = count_q - TW'(1);
    end
  end

  // Count register; initialised by the owner through load.
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;
  assign last  = (count_q == TW'(1));

endmodule

// File: rtl/traffic_ctrl_nlane.sv
// N-lane round-robin traffic-light controller with built-in phase timer.
// Optional build macro TRAFFIC_FLASH_EN adds the flash_mode input and a
// flashing-yellow FLASH phase.
module traffic_ctrl_nlane
  import traffic_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int TW        = DEFAULT_TW,
  parameter int ALL_RED   = 1,
  parameter int LW        = $clog2(NUM_LANES)
) (
  input  logic                   clk_1hz,
  input  logic                   reset_n,
  input  logic                   enable,
`ifdef TRAFFIC_FLASH_EN
  input  logic                   flash_mode,
`endif
  input  logic [NUM_LANES*TW-1:0] preset_green,
  input  logic [NUM_LANES*TW-1:0] preset_yellow,
  input  logic [TW-1:0]           preset_allred,
  output logic [NUM_LANES-1:0]    lane_red,
  output logic [NUM_LANES-1:0]    lane_yellow,
  output logic [NUM_LANES-1:0]    lane_green,
  output logic [LW-1:0]           active_lane,
  output logic [TW-1:0]           countdown,
  output logic                    phase_done
);

  phase_e               state_q, state_d;
  logic [LW-1:0]        lane_q, lane_d, lane_nx;
  logic                 pd_q, pd_d;
  logic [NUM_LANES-1:0] red_q, red_d, yel_q, yel_d, grn_q, grn_d;
  logic                 tmr_ld, tmr_en, tmr_last;
  logic [TW-1:0]        tmr_val, tmr_cnt;
  logic [TW-1:0]        y_cur, g_nx;
`ifdef TRAFFIC_FLASH_EN
  logic                 flash_q, flash_d;
`endif

  function automatic logic [TW-1:0] eff(input logic [TW-1:0] p);
    return TW'(eff_preset(32'(p)));
  endfunction

  phase_timer #(.TW(TW)) u_timer (
    .clk      (clk_1hz),
    .load     (tmr_ld),
    .load_val (tmr_val),
    .en       (tmr_en),
    .count    (tmr_cnt),
    .last     (tmr_last)
  );

  assign lane_nx = (lane_q == LW'(NUM_LANES - 1)) ? '0 : lane_q + LW'(1);
  assign y_cur   = preset_yellow[int'(lane_q) * TW +: TW];
  assign g_nx    = preset_green[int'(lane_nx) * TW +: TW];

  // Next phase, lane and timer reload; reset overrides everything, enable gates the rest.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    pd_d    = 1'b0;
    tmr_ld  = 1'b0;
    tmr_val = tmr_cnt;
    tmr_en  = 1'b0;
`ifdef TRAFFIC_FLASH_EN
    flash_d = flash_q;
`endif
    if (!reset_n) begin
      state_d = GREEN;
      lane_d  = '0;
      tmr_ld  = 1'b1;
      tmr_val = eff(preset_green[TW-1:0]);
`ifdef TRAFFIC_FLASH_EN
      flash_d = 1'b0;
`endif
    end else if (enable) begin
`ifdef TRAFFIC_FLASH_EN
      if (flash_mode && (state_q != FLASH)) begin
        state_d = FLASH;
        flash_d = 1'b1;
        tmr_ld  = 1'b1;
        tmr_val = '0;
        pd_d    = 1'b1;
      end else if (state_q == FLASH) begin
        if (!flash_mode) begin
          // Leave flash through a clearance interval; last lane index so lane 0 goes next.
          state_d = ALLRED;
          lane_d  = LW'(NUM_LANES - 1);
          flash_d = 1'b0;
          tmr_ld  = 1'b1;
          tmr_val = eff(preset_allred);
          pd_d    = 1'b1;
        end else begin
          flash_d = ~flash_q;
        end
      end else
`endif
      begin
        tmr_en = 1'b1;
        if (tmr_last) begin
          pd_d   = 1'b1;
          tmr_ld = 1'b1;
          case (state_q)
            GREEN: begin
              state_d = YELLOW;
              tmr_val = eff(y_cur);
            end
            YELLOW: begin
              if ((ALL_RED != 0) && (preset_allred != '0)) begin
                state_d = ALLRED;
                tmr_val = eff(preset_allred);
              end else begin
                state_d = GREEN;
                lane_d  = lane_nx;
                tmr_val = eff(g_nx);
              end
            end
            default: begin
              state_d = GREEN;
              lane_d  = lane_nx;
              tmr_val = eff(g_nx);
            end
          endcase
        end
      end
    end
  end

  // Lamp decode from the next phase so lamps are registered alongside the state.
  always_comb begin
    red_d = {NUM_LANES{1'b1}};
    yel_d = '0;
    grn_d = '0;
    case (state_d)
      GREEN: begin
        grn_d = NUM_LANES'(1) << lane_d;
        red_d = ~grn_d;
      end
      YELLOW: begin
        yel_d = NUM_LANES'(1) << lane_d;
        red_d = ~yel_d;
      end
`ifdef TRAFFIC_FLASH_EN
      FLASH: begin
        red_d = '0;
        yel_d = {NUM_LANES{flash_d}};
      end
`endif
      default: begin
        red_d = {NUM_LANES{1'b1}};
      end
    endcase
  end

  // Phase, lane, lamp and pulse registers.
  always_ff @(posedge clk_1hz) begin
    state_q <= state_d;
    lane_q  <= lane_d;
    pd_q    <= pd_d;
    red_q   <= red_d;
    yel_q   <= yel_d;
    grn_q   <= grn_d;
`ifdef TRAFFIC_FLASH_EN
    flash_q <= flash_d;
`endif
  end

  assign lane_red    = red_q;
  assign lane_yellow = yel_q;
  assign lane_green  = grn_q;
  assign active_lane = lane_q;
  assign countdown   = tmr_cnt;
  assign phase_done  = pd_q;

endmodule
